// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage. It holds the PC, looks it up in a direct-mapped,
// one-word-per-line instruction cache, and on a miss pulls the 32-bit word
// byte by byte from the memory controller. Hits deliver one instruction per
// cycle. The stage honours a pipeline stall and a branch redirect.
//
// Handshake: the fetch request is level-based. mem_req_o stays high with
// mem_addr_o pointing at the next byte. Every cycle with mem_valid_i high
// accepts exactly one byte, and mem_addr_o then advances. The delivery side
// is a one-cycle pulse. inst_valid_o marks the single cycle in which
// pc_o/inst_o carry a new instruction, and IF/ID must capture it then.
//
// Ports:
//   clk              system clock, rising edge
//   rst              asynchronous, active-low reset
//   stall_i          hold delivery (load-use stall)
//   branch_i         redirect request; wins over stall and delivery
//   branch_target_i  redirect PC
//   mem_req_o        fetch request to memory controller
//   mem_addr_o       byte address of the current request
//   mem_data_i       returned byte
//   mem_valid_i      mem_data_i valid this cycle
//   pc_o             PC of delivered instruction
//   inst_o           delivered instruction (little-endian assembled)
//   inst_valid_o     one-cycle pulse: new instruction on pc_o/inst_o
//   dbg_state_o      current FSM state (0 LOOKUP, 1 FETCH, 2 HOLD, 3 ABORT)
// -----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          ICACHE_LINES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic [7:0]  mem_data_i,
    input  logic        mem_valid_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic [1:0]  dbg_state_o
);

    localparam int IDX_W = $clog2(ICACHE_LINES);
    localparam int TAG_W = 32 - IDX_W - 2;

    typedef enum logic [1:0] {
        LOOKUP = 2'd0,
        FETCH  = 2'd1,
        HOLD   = 2'd2,
        ABORT  = 2'd3
    } state_t;

    state_t                    state;
    logic [31:0]               pc;
    logic [1:0]                cnt;
    logic [31:0]               fill_buf;
    logic [ICACHE_LINES-1:0]   valid_q;
    logic [TAG_W-1:0]          tag_mem  [ICACHE_LINES];
    logic [31:0]               data_mem [ICACHE_LINES];

    logic [IDX_W-1:0]          idx;
    logic [TAG_W-1:0]          pc_tag;
    logic                      hit;
    logic [31:0]               pc_inc;
    logic [1:0]                cnt_inc;
    logic [31:0]               fetched_word;
    logic                      cache_we;

    assign idx          = pc[IDX_W+1:2];
    assign pc_tag       = pc[31:IDX_W+2];
    assign hit          = valid_q[idx] && (tag_mem[idx] == pc_tag);
    assign pc_inc       = pc + 32'd4;
    assign cnt_inc      = cnt + 2'd1;
    // The last byte lands straight from the bus, so the full word is only
    // visible combinationally on the final beat.
    assign fetched_word = {mem_data_i, fill_buf[23:0]};
    // A line is written only when all four bytes arrived and no redirect
    // is discarding them in the same cycle.
    assign cache_we     = (state == FETCH) && mem_valid_i && !branch_i && (cnt == 2'd3);
    assign dbg_state_o  = state;

    // Tag/data storage carries no reset; the valid bits gate every hit.
    always_ff @(posedge clk) begin
        if (cache_we) begin
            tag_mem[idx]  <= pc_tag;
            data_mem[idx] <= fetched_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= LOOKUP;
            pc           <= RESET_PC;
            cnt          <= 2'd0;
            fill_buf     <= 32'd0;
            valid_q      <= '0;
            mem_req_o    <= 1'b0;
            mem_addr_o   <= 32'd0;
            pc_o         <= 32'd0;
            inst_o       <= 32'd0;
            inst_valid_o <= 1'b0;
        end else begin
            inst_valid_o <= 1'b0;
            if (cache_we) begin
                valid_q[idx] <= 1'b1;
            end

            case (state)
                LOOKUP: begin
                    if (branch_i) begin
                        pc  <= branch_target_i;
                        cnt <= 2'd0;
                    end else if (hit) begin
                        if (!stall_i) begin
                            pc_o         <= pc;
                            inst_o       <= data_mem[idx];
                            inst_valid_o <= 1'b1;
                            pc           <= pc_inc;
                        end
                    end else begin
                        cnt        <= 2'd0;
                        mem_req_o  <= 1'b1;
                        mem_addr_o <= pc;
                        state      <= FETCH;
                    end
                end

                FETCH: begin
                    if (branch_i) begin
                        pc        <= branch_target_i;
                        cnt       <= 2'd0;
                        fill_buf  <= 32'd0;
                        mem_req_o <= 1'b0;
                        // A started transfer needs one idle request cycle so
                        // the controller abandons the stale address.
                        state     <= ((cnt != 2'd0) || mem_valid_i) ? ABORT : LOOKUP;
                    end else if (mem_valid_i) begin
                        fill_buf[{cnt, 3'b000} +: 8] <= mem_data_i;
                        if (cnt == 2'd3) begin
                            cnt       <= 2'd0;
                            mem_req_o <= 1'b0;
                            fill_buf  <= fetched_word;
                            if (!stall_i) begin
                                pc_o         <= pc;
                                inst_o       <= fetched_word;
                                inst_valid_o <= 1'b1;
                                pc           <= pc_inc;
                                state        <= LOOKUP;
                            end else begin
                                state <= HOLD;
                            end
                        end else begin
                            cnt        <= cnt_inc;
                            mem_addr_o <= pc + {30'd0, cnt_inc};
                        end
                    end
                end

                HOLD: begin
                    if (branch_i) begin
                        pc       <= branch_target_i;
                        cnt      <= 2'd0;
                        fill_buf <= 32'd0;
                        state    <= LOOKUP;
                    end else if (!stall_i) begin
                        pc_o         <= pc;
                        inst_o       <= fill_buf;
                        inst_valid_o <= 1'b1;
                        pc           <= pc_inc;
                        state        <= LOOKUP;
                    end
                end

                ABORT: begin
                    // A redirect here restarts the idle cycle with the new PC.
                    if (branch_i) begin
                        pc  <= branch_target_i;
                        cnt <= 2'd0;
                    end else begin
                        state <= LOOKUP;
                    end
                end

                default: state <= LOOKUP;
            endcase
        end
    end

endmodule
